ldm_stm_sequencer: RTL and testbench
====================================

# ldm_stm_sequencer

Multi-cycle sequencer for ARM block data transfers (LDM/STM). Walks a 16-bit register list in ascending order and generates one memory access per listed register. Drives the register file's read-port select (store data), write select, write data and load enable (load data and base writeback). Sits directly upstream of the register file on its write path and beside the MAR/memory interface.

## Interface
Parameters:
- none; word size fixed at 32 bits, address step fixed at 4 bytes.

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-high
- Start  in  1  begin a transfer; sampled only in IDLE
- RegList  in  16  bit i set = transfer Ri
- Base  in  32  current value of base register Rn
- Rn  in  4  base register number
- L  in  1  1 = load (LDM), 0 = store (STM)
- U  in  1  1 = increment, 0 = decrement
- P  in  1  1 = pre-index (before), 0 = post (after)
- W  in  1  base writeback enable
- MOC  in  1  memory operation complete
- MemData  in  32  memory read data, valid when MOC=1 on a read
- MAR  out  32  memory word address
- MemRead  out  1  read strobe
- MemWrite  out  1  write strobe
- RegAddrB  out  4  register-file read-port B select (store data source)
- RegAddrC  out  4  register-file write select
- RegWrData  out  32  register-file write data
- RF  out  1  register-file load enable, active-high, one cycle per write
- Busy  out  1  high from SETUP through DONE
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SETUP, ACCESS, WRITE, WB, DONE.
- IDLE: Start=1 at a rising edge latches RegList into the remaining-mask, plus Base, Rn, L, U, P and W. Next state is SETUP. Start in any other state is ignored.
- SETUP: N = popcount(RegList), 0..16.
  - Start address: IA Base; IB Base+4; DA Base−4N+4; DB Base−4N.
  - Writeback value: U ? Base+4N : Base−4N, modulo 2^32.
  - N=0: next state is DONE, with no access and no writeback.
  - Otherwise: next state is ACCESS.
- Current register = lowest set bit of the remaining mask. The lowest register always goes to the lowest address.
- ACCESS: drives MAR = current address.
  - Store: MemWrite=1 and RegAddrB = current register.
  - Load: MemRead=1.
  - Strobes, MAR and RegAddrB stay constant until the edge where MOC=1.
  - On that edge: load captures MemData and goes to WRITE. Store clears the current bit and adds 4 to the address.
  - Store next state: another bit remains → ACCESS; none remain → WB if W=1, else DONE.
- WRITE: RF=1, RegAddrC = current register, RegWrData = captured data. Clears the bit, adds 4 to the address, then branches exactly as a store does after ACCESS.
- WB: RF=1, RegAddrC = Rn, RegWrData = writeback value. Next state is DONE.
- Writeback is suppressed (WB skipped) when L=1 and Rn is in RegList; the loaded value wins. STM with Rn in the list stores the original Base value.
- R15 is loaded like any other register; branch handling is outside this block.
- DONE: Done=1 for one cycle, then IDLE.

## Timing
- Reset (asynchronous) forces IDLE. All outputs go to 0, including the strobes and RF, with no clock edge needed.
- Reset during any state aborts the transfer with no further RF pulse. Registers already written keep their values.
- Outputs are Moore: a function of state and latched registers only. MOC and MemData are sampled on the rising edge.
- Cycle counts with MOC tied high:
  - Store transfer: 1 cycle. Load transfer: 2 cycles (ACCESS + WRITE).
  - Start edge to Done = 1 (SETUP) + transfers + W·1 + 1 cycles.
  - STM N=3 with W=1: Done is high in the 6th cycle after the Start edge.
- Each MOC-low cycle in ACCESS adds one cycle.
- Address arithmetic wraps modulo 2^32; no alignment check.

## Structure
- Shared package/header holds:
  - the state encoding constants
  - WORD_BYTES = 4
  - the addressing-mode encodings {P,U}: IA=01, IB=11, DA=00, DB=10
- Sub-module lowest_set_bit: combinational, 16-bit mask in; 4-bit index and a valid flag out.
- Popcount and address adders stay inline.

## Test plan
- STM IA, RegList=0x000E, Base=0x100, Rn=4, W=1, MOC=1:
  - MAR 0x100/0x104/0x108 with RegAddrB 1/2/3.
  - Then RF=1, RegAddrC=4, RegWrData=0x10C.
  - Done in the 6th cycle.
- LDM DB, RegList=0x8001, Base=0x200, W=0:
  - MAR 0x1F8 then 0x1FC.
  - RF pulses with RegAddrC=0 then 15, carrying MemData 0xAAAA0000 and 0x5555FFFF.
  - No WB.
- STM IB, one register, MOC held low 3 cycles after MemWrite rises:
  - MAR=Base+4 and MemWrite stay stable for 4 cycles.
  - Advance occurs on the MOC edge only.
- RegList=0x0000, W=1: Done in the 2nd cycle after Start; no strobe and no RF ever.
- LDM IA, Rn=2, RegList=0x0004, W=1: exactly one RF pulse (loaded data to R2); writeback suppressed.
- Reset asserted mid-ACCESS of a 4-register STM:
  - Strobes and Busy drop immediately; no RF.
  - A new Start after reset runs normally from address recomputation.

Source files
------------

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StWrite,
    StWb,
    StDone
  } state_e;

  localparam int unsigned WordBytes = 4;

  // Addressing-mode encodings, indexed by {P,U}
  localparam logic [1:0] ModeIa = 2'b01;
  localparam logic [1:0] ModeIb = 2'b11;
  localparam logic [1:0] ModeDa = 2'b00;
  localparam logic [1:0] ModeDb = 2'b10;

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Command, memory and register-file signals of the LDM/STM sequencer.
interface ldm_stm_sequencer_if;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base;
  logic [3:0]  rn;
  logic        l;
  logic        u;
  logic        p;
  logic        w;
  logic        moc;
  logic [31:0] mem_data;
  logic [31:0] mar;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  reg_addr_b;
  logic [3:0]  reg_addr_c;
  logic [31:0] reg_wr_data;
  logic        rf;
  logic        busy;
  logic        done;

  modport master (
    output start, reg_list, base, rn, l, u, p, w, moc, mem_data,
    input  mar, mem_read, mem_write, reg_addr_b, reg_addr_c, reg_wr_data, rf, busy, done
  );

  modport slave (
    input  start, reg_list, base, rn, l, u, p, w, moc, mem_data,
    output mar, mem_read, mem_write, reg_addr_b, reg_addr_c, reg_wr_data, rf, busy, done
  );
endinterface

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a 16-bit mask.
module ldm_stm_sequencer_lowest_set_bit (
  input  logic [15:0] i_mask,
  output logic [3:0]  o_index,
  output logic        o_valid
);
  always_comb begin
    o_index = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i_mask[i]) o_index = 4'(i);
    end
    o_valid = |i_mask;
  end
endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list in ascending order, one memory access
// per listed register, then optionally writes the updated base back to Rn.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  ldm_stm_sequencer_if.slave    io_bus
);
  localparam logic [31:0] Step = 32'(WordBytes);

  state_e      r_state, w_state_next, w_after;
  logic [15:0] r_mask, w_mask_clr;
  logic [31:0] r_base, r_addr, r_wb_val, r_data;
  logic [31:0] w_span, w_start_addr, w_wb_val;
  logic [3:0]  r_rn, w_cur;
  logic [4:0]  w_count;
  logic        r_l, r_u, r_p, r_w, r_wb_skip, w_cur_valid;

  ldm_stm_sequencer_lowest_set_bit u_lsb (
    .i_mask  (r_mask),
    .o_index (w_cur),
    .o_valid (w_cur_valid)
  );

  always_comb begin
    w_count = '0;
    for (int i = 0; i < 16; i++) w_count = w_count + {4'b0, r_mask[i]};
    w_span = {25'b0, w_count, 2'b0};
    case ({r_p, r_u})
      ModeIa:  w_start_addr = r_base;
      ModeIb:  w_start_addr = r_base + Step;
      ModeDa:  w_start_addr = r_base - w_span + Step;
      default: w_start_addr = r_base - w_span;
    endcase
    w_wb_val   = r_u ? r_base + w_span : r_base - w_span;
    w_mask_clr = r_mask & ~(16'h0001 << w_cur);
    // Loaded Rn beats the writeback value, so WB is skipped in that case
    if (|w_mask_clr)           w_after = StAccess;
    else if (r_w && !r_wb_skip) w_after = StWb;
    else                       w_after = StDone;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next       = r_state;
    io_bus.mar         = '0;
    io_bus.mem_read    = 1'b0;
    io_bus.mem_write   = 1'b0;
    io_bus.reg_addr_b  = '0;
    io_bus.reg_addr_c  = '0;
    io_bus.reg_wr_data = '0;
    io_bus.rf          = 1'b0;
    io_bus.busy        = (r_state != StIdle);
    io_bus.done        = 1'b0;
    unique case (r_state)
      StIdle:  if (io_bus.start) w_state_next = StSetup;
      StSetup: w_state_next = w_cur_valid ? StAccess : StDone;
      StAccess: begin
        io_bus.mar       = r_addr;
        io_bus.mem_read  = r_l;
        io_bus.mem_write = !r_l;
        if (!r_l) io_bus.reg_addr_b = w_cur;
        if (io_bus.moc) w_state_next = r_l ? StWrite : w_after;
      end
      StWrite: begin
        io_bus.rf          = 1'b1;
        io_bus.reg_addr_c  = w_cur;
        io_bus.reg_wr_data = r_data;
        w_state_next       = w_after;
      end
      StWb: begin
        io_bus.rf          = 1'b1;
        io_bus.reg_addr_c  = r_rn;
        io_bus.reg_wr_data = r_wb_val;
        w_state_next       = StDone;
      end
      StDone: begin
        io_bus.done  = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mask    <= '0;
      r_base    <= '0;
      r_addr    <= '0;
      r_wb_val  <= '0;
      r_data    <= '0;
      r_rn      <= '0;
      r_l       <= 1'b0;
      r_u       <= 1'b0;
      r_p       <= 1'b0;
      r_w       <= 1'b0;
      r_wb_skip <= 1'b0;
    end else begin
      case (r_state)
        StIdle: if (io_bus.start) begin
          r_mask    <= io_bus.reg_list;
          r_base    <= io_bus.base;
          r_rn      <= io_bus.rn;
          r_l       <= io_bus.l;
          r_u       <= io_bus.u;
          r_p       <= io_bus.p;
          r_w       <= io_bus.w;
          r_wb_skip <= io_bus.l && io_bus.reg_list[io_bus.rn];
        end
        StSetup: begin
          r_addr   <= w_start_addr;
          r_wb_val <= w_wb_val;
        end
        StAccess: if (io_bus.moc) begin
          if (r_l) begin
            r_data <= io_bus.mem_data;
          end else begin
            r_mask <= w_mask_clr;
            r_addr <= r_addr + Step;
          end
        end
        StWrite: begin
          r_mask <= w_mask_clr;
          r_addr <= r_addr + Step;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboarded bench for ldm_stm_sequencer: expected bus/RF events are queued per scenario
// and matched by a monitor as the sequencer produces them.
module tb_ldm_stm_sequencer;
  localparam logic [1:0] KWr = 2'd0;
  localparam logic [1:0] KRd = 2'd1;
  localparam logic [1:0] KRf = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [3:0]  rg;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [31:0] mem [logic [31:0]];

  ldm_stm_sequencer_if bus ();

  ldm_stm_sequencer dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: read data presented while a read is outstanding
  always @(negedge clk) begin
    if (bus.mem_read) bus.mem_data = mem.exists(bus.mar) ? mem[bus.mar] : ~bus.mar;
  end

  // Monitor: completed accesses and RF writes are matched against the scoreboard
  always @(negedge clk) begin
    ev_t obs, e;
    logic hit;
    hit = 1'b0;
    obs = '0;
    if (!rst) begin
      if ((bus.mem_write || bus.mem_read) && bus.moc) begin
        hit      = 1'b1;
        obs.kind = bus.mem_write ? KWr : KRd;
        obs.addr = bus.mar;
        obs.rg   = bus.mem_write ? bus.reg_addr_b : 4'd0;
      end else if (bus.rf) begin
        hit      = 1'b1;
        obs.kind = KRf;
        obs.rg   = bus.reg_addr_c;
        obs.data = bus.reg_wr_data;
      end
    end
    if (hit) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected kind=%0d addr=%h reg=%0d data=%h, none required",
                 obs.kind, obs.addr, obs.rg, obs.data);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL event: got kind=%0d addr=%h reg=%0d data=%h, want kind=%0d addr=%h reg=%0d data=%h",
                   obs.kind, obs.addr, obs.rg, obs.data, e.kind, e.addr, e.rg, e.data);
        end
      end
    end
  end

  function automatic ev_t mk(input logic [1:0] k, input logic [31:0] a, input logic [3:0] r,
                             input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.rg   = r;
    e.data = d;
    return e;
  endfunction

  task automatic start_xfer(input logic [15:0] list, input logic [31:0] b, input logic [3:0] n,
                            input logic l, input logic u, input logic p, input logic w);
    @(negedge clk);
    bus.reg_list = list;
    bus.base     = b;
    bus.rn       = n;
    bus.l        = l;
    bus.u        = u;
    bus.p        = p;
    bus.w        = w;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Cycle 1 is the cycle after the Start edge; -1 means Done never arrived
  task automatic wait_done(output int cyc, output int n_strobe, output int n_rf);
    cyc = -1;
    n_strobe = 0;
    n_rf = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) n_strobe++;
      if (bus.rf) n_rf++;
      if (bus.done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.mem_read !== 1'b0)  begin errors++; $display("FAIL reset_rd: got %b want 0", bus.mem_read); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", bus.mem_write); end
    checks++; if (bus.rf !== 1'b0)        begin errors++; $display("FAIL reset_rf: got %b want 0", bus.rf); end
    checks++; if (bus.mar !== 32'h0)      begin errors++; $display("FAIL reset_mar: got %h want 0", bus.mar); end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_stm_ia();
    int cyc, ns, nr;
    exp_q.push_back(mk(KWr, 32'h100, 4'd1, 32'h0));
    exp_q.push_back(mk(KWr, 32'h104, 4'd2, 32'h0));
    exp_q.push_back(mk(KWr, 32'h108, 4'd3, 32'h0));
    exp_q.push_back(mk(KRf, 32'h0, 4'd4, 32'h10C));
    start_xfer(16'h000E, 32'h100, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done(cyc, ns, nr);
    checks++; if (cyc != 6) begin errors++; $display("FAIL stm_ia_done_cycle: got %0d want 6", cyc); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL stm_ia_after_done: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stm_ia_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_ldm_db();
    int cyc, ns, nr;
    mem[32'h1F8] = 32'hAAAA0000;
    mem[32'h1FC] = 32'h5555FFFF;
    exp_q.push_back(mk(KRd, 32'h1F8, 4'd0, 32'h0));
    exp_q.push_back(mk(KRf, 32'h0, 4'd0, 32'hAAAA0000));
    exp_q.push_back(mk(KRd, 32'h1FC, 4'd0, 32'h0));
    exp_q.push_back(mk(KRf, 32'h0, 4'd15, 32'h5555FFFF));
    start_xfer(16'h8001, 32'h200, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done(cyc, ns, nr);
    checks++; if (cyc != 6) begin errors++; $display("FAIL ldm_db_done_cycle: got %0d want 6", cyc); end
    checks++; if (nr != 2)  begin errors++; $display("FAIL ldm_db_rf_count: got %0d want 2", nr); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ldm_db_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_moc_stall();
    int cyc, ns, nr, found;
    found = 0;
    bus.moc = 1'b0;
    exp_q.push_back(mk(KWr, 32'h304, 4'd5, 32'h0));
    start_xfer(16'h0020, 32'h300, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_write) begin
        found = 1;
        break;
      end
    end
    checks++; if (found != 1) begin errors++; $display("FAIL stall_write_rise: got %0d want 1", found); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 if (i == 2) bus.moc = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_write !== 1'b1 || bus.mar !== 32'h304) begin
        errors++;
        $display("FAIL stall_hold_%0d: got wr=%b mar=%h want 1 00000304", i, bus.mem_write, bus.mar);
      end
    end
    wait_done(cyc, ns, nr);
    checks++; if (cyc != 1 || ns != 0) begin
      errors++; $display("FAIL stall_advance: got cyc=%0d strobes=%0d want 1 0", cyc, ns);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_empty_list();
    int cyc, ns, nr;
    start_xfer(16'h0000, 32'h700, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_done(cyc, ns, nr);
    checks++; if (cyc != 2) begin errors++; $display("FAIL empty_done_cycle: got %0d want 2", cyc); end
    checks++; if (ns != 0 || nr != 0) begin
      errors++; $display("FAIL empty_activity: got strobes=%0d rf=%0d want 0 0", ns, nr);
    end
  endtask

  task automatic test_wb_suppress();
    int cyc, ns, nr;
    mem[32'h600] = 32'h12345678;
    exp_q.push_back(mk(KRd, 32'h600, 4'd0, 32'h0));
    exp_q.push_back(mk(KRf, 32'h0, 4'd2, 32'h12345678));
    start_xfer(16'h0004, 32'h600, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_done(cyc, ns, nr);
    checks++; if (nr != 1)  begin errors++; $display("FAIL wbs_rf_count: got %0d want 1", nr); end
    checks++; if (cyc != 4) begin errors++; $display("FAIL wbs_done_cycle: got %0d want 4", cyc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wbs_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_access();
    int cyc, ns, nr, found;
    found = 0;
    exp_q.push_back(mk(KWr, 32'h400, 4'd4, 32'h0));
    exp_q.push_back(mk(KWr, 32'h404, 4'd5, 32'h0));
    start_xfer(16'h00F0, 32'h400, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_write && bus.mar == 32'h404) begin
        found = 1;
        break;
      end
    end
    checks++; if (found != 1) begin errors++; $display("FAIL rst_reach_access: got %0d want 1", found); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.mem_write !== 1'b0 || bus.busy !== 1'b0 || bus.rf !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got wr=%b busy=%b rf=%b want 0 0 0", bus.mem_write, bus.busy, bus.rf);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_pending: got %0d want 0", exp_q.size()); end
    exp_q.push_back(mk(KWr, 32'h4FC, 4'd0, 32'h0));
    exp_q.push_back(mk(KWr, 32'h500, 4'd1, 32'h0));
    exp_q.push_back(mk(KRf, 32'h0, 4'd9, 32'h4F8));
    start_xfer(16'h0003, 32'h500, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(cyc, ns, nr);
    checks++; if (cyc != 5) begin errors++; $display("FAIL rst_restart_cycle: got %0d want 5", cyc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_restart_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.reg_list = '0;
    bus.base     = '0;
    bus.rn       = '0;
    bus.l        = 1'b0;
    bus.u        = 1'b0;
    bus.p        = 1'b0;
    bus.w        = 1'b0;
    bus.moc      = 1'b1;
    bus.mem_data = '0;
    test_reset();
    test_stm_ia();
    test_ldm_db();
    test_moc_stall();
    test_empty_list();
    test_wb_suppress();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
